// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the decode/EX pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
    parameter int W = 32
);
    logic         start;
    logic [3:0]   con;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hiloR;
    logic         hiloS;
    logic [W-1:0] hilo_out;
    logic         busy;
    logic         stall;
    logic         done;
    logic         dz;

    modport master (
        output start, con, a, b, hiloR, hiloS,
        input  hilo_out, busy, stall, done, dz
    );

    modport slave (
        input  start, con, a, b, hiloR, hiloS,
        output hilo_out, busy, stall, done, dz
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 signed/unsigned multiply/divide engine with HI/LO registers and stall control.
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle combinational multiplier.
module hilo_muldiv_unit #(
    parameter int W = 32
) (
    input logic          clk,
    input logic          rst,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                state, stateNext;
    logic [W-1:0]          hi, lo;
    logic [W-1:0]          accHi, accLo, opB;
    logic [CW-1:0]         count;
    logic                  isDiv, negRes, signA, divZeroR;
    logic                  done, dz;

    logic                  accept, divZero, fastPath, sA, sB;
    logic [W-1:0]          magA, magB;
    logic [W:0]            mulSum, divShift, divDiff;
    logic [2*W-1:0]        prodRaw, prodFix;
    logic [W-1:0]          quoFix, remFix;

    function automatic logic [W-1:0] condNeg(input logic [W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*W-1:0] condNegWide(input logic [2*W-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign accept  = (state == IDLE) && bus.start && (bus.con[3:2] == 2'b11);
    assign divZero = bus.con[0] && (bus.b == '0);
    assign sA      = bus.con[1] && bus.a[W-1];
    assign sB      = bus.con[1] && bus.b[W-1];
    assign magA    = condNeg(bus.a, sA);
    assign magB    = condNeg(bus.b, sB);

`ifdef MULDIV_FAST_MUL_EN
    assign fastPath = !bus.con[0];
    assign prodRaw  = {{W{1'b0}}, opB} * {{W{1'b0}}, accLo};
`else
    assign fastPath = 1'b0;
    assign prodRaw  = {accHi, accLo};
`endif

    // Shift-add step: conditionally add the multiplicand, then shift the 2W product right.
    assign mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, opB} : '0);
    // Restoring step: the W+1 bit shifted remainder never needs more than bit W as the borrow.
    assign divShift = {accHi, accLo[W-1]};
    assign divDiff  = divShift - {1'b0, opB};

    assign prodFix  = condNegWide(prodRaw, negRes);
    assign quoFix   = condNeg(accLo, negRes);
    assign remFix   = condNeg(accHi, signA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (divZero || fastPath) stateNext = FIX;
                    else                     stateNext = RUN;
                end
            end
            RUN:     if (count == '0) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= '0;
            lo       <= '0;
            accHi    <= '0;
            accLo    <= '0;
            opB      <= '0;
            count    <= '0;
            isDiv    <= 1'b0;
            negRes   <= 1'b0;
            signA    <= 1'b0;
            divZeroR <= 1'b0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        isDiv    <= bus.con[0];
                        negRes   <= sA ^ sB;
                        signA    <= sA;
                        divZeroR <= divZero;
                        dz       <= 1'b0;
                        count    <= CW'(W - 1);
                        accHi    <= '0;
                        // Divide keeps the dividend in accLo; multiply keeps the multiplier there.
                        accLo    <= bus.con[0] ? magA : magB;
                        opB      <= bus.con[0] ? magB : magA;
                    end
                end
                RUN: begin
                    count <= count - 1'b1;
                    if (isDiv) begin
                        accHi <= divDiff[W] ? divShift[W-1:0] : divDiff[W-1:0];
                        accLo <= {accLo[W-2:0], ~divDiff[W]};
                    end else begin
                        accHi <= mulSum[W:1];
                        accLo <= {mulSum[0], accLo[W-1:1]};
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (divZeroR) begin
                        dz <= 1'b1;
                    end else if (isDiv) begin
                        hi <= remFix;
                        lo <= quoFix;
                    end else begin
                        hi <= prodFix[2*W-1:W];
                        lo <= prodFix[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.stall    = bus.busy && (bus.hiloR || bus.start);
    assign bus.hilo_out = bus.hiloS ? lo : hi;
    assign bus.done     = done;
    assign bus.dz       = dz;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard-based bench for hilo_muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_hilo_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 33;
`endif
    localparam int DIV_CYC = 33;
    localparam int BOUND   = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_muldiv_if #(.W(W)) bus();
    hilo_muldiv_unit #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int nChecks = 0;
    int nErrors = 0;
    logic [2*W-1:0] sbQ[$];
    logic [W-1:0]   mHi = '0, mLo = '0;

    function automatic logic [2*W-1:0] model(input logic [3:0] con, input logic [W-1:0] a, b,
                                             input logic [W-1:0] oldHi, oldLo);
        longint sa, sb;
        logic [63:0] p, q, r;
        if (!con[0]) begin
            if (con[1]) begin
                sa = $signed(a); sb = $signed(b); p = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            return p;
        end
        if (b == '0) return {oldHi, oldLo};
        if (con[1]) begin
            sa = $signed(a); sb = $signed(b); q = sa / sb; r = sa % sb;
        end else begin
            q = {32'b0, a} / {32'b0, b}; r = {32'b0, a} % {32'b0, b};
        end
        return {r[31:0], q[31:0]};
    endfunction

    task automatic issue(input logic [3:0] con, input logic [W-1:0] a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.con = con; bus.a = a; bus.b = b;
        if (con[3:2] == 2'b11 && !bus.busy) sbQ.push_back(model(con, a, b, mHi, mLo));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(output int cyc, output logic sawDone);
        cyc = 0;
        while (bus.busy && cyc < BOUND) begin
            cyc++;
            @(negedge clk);
        end
        sawDone = bus.done;
    endtask

    task automatic readHiLo(output logic [W-1:0] h, output logic [W-1:0] l);
        bus.hiloS = 1'b0; #1 h = bus.hilo_out;
        bus.hiloS = 1'b1; #1 l = bus.hilo_out;
    endtask

    task automatic test_reset;
        logic [W-1:0] h, l;
        rst = 1'b1;
        bus.start = 0; bus.con = 0; bus.a = 0; bus.b = 0; bus.hiloR = 0; bus.hiloS = 0;
        repeat (2) @(negedge clk);
        readHiLo(h, l);
        nChecks++;
        if (h !== 0 || l !== 0 || bus.busy !== 0 || bus.done !== 0 || bus.dz !== 0 || bus.stall !== 0) begin
            nErrors++;
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b dz=%b stall=%b, want all zero",
                     h, l, bus.busy, bus.done, bus.dz, bus.stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        logic [3:0]   tc[8] = '{4'b1100, 4'b1110, 4'b1101, 4'b1111, 4'b1111, 4'b1110, 4'b1101, 4'b1100};
        logic [W-1:0] ta[8] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd100, 32'hFFFFFFF9,
                                32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
        logic [W-1:0] tb[8] = '{32'hFFFFFFFF, 32'd7, 32'd7, 32'd2,
                                32'hFFFFFFFF, 32'h80000000, 32'h00010000, 32'h9ABCDEF0};
        int cyc, expCyc;
        logic sawDone;
        logic [2*W-1:0] exp;
        logic [W-1:0] h, l;
        for (int i = 0; i < 8; i++) begin
            issue(tc[i], ta[i], tb[i]);
            waitDone(cyc, sawDone);
            expCyc = tc[i][0] ? DIV_CYC : MUL_CYC;
            exp = sbQ.pop_front();
            mHi = exp[2*W-1:W]; mLo = exp[W-1:0];
            readHiLo(h, l);
            nChecks++;
            if (cyc !== expCyc) begin
                nErrors++;
                $display("FAIL arith%0d busy cycles: got %0d want %0d", i, cyc, expCyc);
            end
            nChecks++;
            if (sawDone !== 1'b1) begin
                nErrors++;
                $display("FAIL arith%0d done pulse: got %b want 1", i, sawDone);
            end
            nChecks++;
            if (h !== mHi || l !== mLo) begin
                nErrors++;
                $display("FAIL arith%0d result: hi=%h lo=%h want hi=%h lo=%h", i, h, l, mHi, mLo);
            end
            @(negedge clk);
            nChecks++;
            if (bus.done !== 1'b0) begin
                nErrors++;
                $display("FAIL arith%0d done width: done=%b one cycle later, want 0", i, bus.done);
            end
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        logic sawDone;
        logic [2*W-1:0] exp;
        logic [W-1:0] h, l;
        issue(4'b1111, 32'd5, 32'd0);
        waitDone(cyc, sawDone);
        exp = sbQ.pop_front();
        readHiLo(h, l);
        nChecks++;
        if (cyc !== 1 || bus.dz !== 1'b1) begin
            nErrors++;
            $display("FAIL divzero: busy cycles=%0d dz=%b, want 1 and 1", cyc, bus.dz);
        end
        nChecks++;
        if (h !== exp[2*W-1:W] || l !== exp[W-1:0]) begin
            nErrors++;
            $display("FAIL divzero hilo: hi=%h lo=%h want unchanged hi=%h lo=%h", h, l, mHi, mLo);
        end
        issue(4'b1100, 32'd3, 32'd4);
        nChecks++;
        if (bus.dz !== 1'b0) begin
            nErrors++;
            $display("FAIL divzero clear: dz=%b after new start, want 0", bus.dz);
        end
        waitDone(cyc, sawDone);
        exp = sbQ.pop_front();
        mHi = exp[2*W-1:W]; mLo = exp[W-1:0];
        readHiLo(h, l);
        nChecks++;
        if (h !== mHi || l !== mLo || bus.dz !== 1'b0) begin
            nErrors++;
            $display("FAIL divzero follow: hi=%h lo=%h dz=%b want hi=%h lo=%h dz=0", h, l, bus.dz, mHi, mLo);
        end
    endtask

    task automatic test_read_and_start;
        int cyc;
        logic sawDone;
        logic [2*W-1:0] exp;
        logic [W-1:0] h, l;
        @(negedge clk);
        bus.start = 1'b1; bus.con = 4'b1100; bus.a = 32'd5; bus.b = 32'd6;
        bus.hiloR = 1'b1; bus.hiloS = 1'b0;
        sbQ.push_back(model(4'b1100, 32'd5, 32'd6, mHi, mLo));
        #1;
        nChecks++;
        if (bus.hilo_out !== mHi || bus.stall !== 1'b0) begin
            nErrors++;
            $display("FAIL readstart: hilo_out=%h stall=%b want %h and 0", bus.hilo_out, bus.stall, mHi);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.hiloR = 1'b0;
        nChecks++;
        if (bus.busy !== 1'b1) begin
            nErrors++;
            $display("FAIL readstart accept: busy=%b want 1", bus.busy);
        end
        waitDone(cyc, sawDone);
        exp = sbQ.pop_front();
        mHi = exp[2*W-1:W]; mLo = exp[W-1:0];
        readHiLo(h, l);
        nChecks++;
        if (h !== mHi || l !== mLo) begin
            nErrors++;
            $display("FAIL readstart result: hi=%h lo=%h want hi=%h lo=%h", h, l, mHi, mLo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic sawDone;
        logic [2*W-1:0] exp;
        logic [W-1:0] h, l;
        issue(4'b1101, 32'd1000, 32'd7);
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.con = 4'b1100; bus.a = 32'd2; bus.b = 32'd2;
        #1;
        nChecks++;
        if (bus.stall !== 1'b1) begin
            nErrors++;
            $display("FAIL b2b stall on start: stall=%b want 1", bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(cyc, sawDone);
        exp = sbQ.pop_front();
        mHi = exp[2*W-1:W]; mLo = exp[W-1:0];
        readHiLo(h, l);
        nChecks++;
        if (h !== mHi || l !== mLo || !sawDone) begin
            nErrors++;
            $display("FAIL b2b first: hi=%h lo=%h done=%b want hi=%h lo=%h done=1", h, l, sawDone, mHi, mLo);
        end
        issue(4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(cyc, sawDone);
        exp = sbQ.pop_front();
        mHi = exp[2*W-1:W]; mLo = exp[W-1:0];
        readHiLo(h, l);
        nChecks++;
        if (h !== mHi || l !== mLo || cyc !== MUL_CYC) begin
            nErrors++;
            $display("FAIL b2b second: hi=%h lo=%h cyc=%0d want hi=%h lo=%h cyc=%0d",
                     h, l, cyc, mHi, mLo, MUL_CYC);
        end
    endtask

    task automatic test_stall_abort;
        logic [W-1:0] h, l;
        logic sawDone;
        issue(4'b1101, 32'd12345, 32'd17);
        repeat (9) @(negedge clk);
        bus.hiloR = 1'b1;
        readHiLo(h, l);
        nChecks++;
        if (bus.stall !== 1'b1 || h !== mHi || l !== mLo) begin
            nErrors++;
            $display("FAIL stall read: stall=%b hi=%h lo=%h want 1 hi=%h lo=%h", bus.stall, h, l, mHi, mLo);
        end
        @(negedge clk);
        bus.hiloR = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.con = 4'b1111; bus.a = 32'd9; bus.b = 32'd3;
        #1;
        nChecks++;
        if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
            nErrors++;
            $display("FAIL stall start: stall=%b busy=%b want 1 1", bus.stall, bus.busy);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        sbQ.delete();
        mHi = '0; mLo = '0;
        readHiLo(h, l);
        nChecks++;
        if (bus.busy !== 1'b0 || h !== 0 || l !== 0) begin
            nErrors++;
            $display("FAIL abort: busy=%b hi=%h lo=%h want 0 0 0", bus.busy, h, l);
        end
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) sawDone = 1'b1;
        end
        nChecks++;
        if (sawDone !== 1'b0) begin
            nErrors++;
            $display("FAIL abort quiet: done/busy seen=%b after abort, want 0", sawDone);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_div_zero();
        test_read_and_start();
        test_back_to_back();
        test_stall_abort();
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end
endmodule
